// File: rtl/cpu_pkg.sv
// Shared types and helpers for the CPU instruction-fetch slice.
package cpu_pkg;

  // Every instruction is one 32-bit word.
  localparam int INSTR_BYTES = 4;

  // One prefetched instruction together with the address it came from.
  typedef struct packed {
    logic [15:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // Force an address onto an instruction boundary.
  function automatic logic [15:0] align_pc(input logic [15:0] pc);
    return pc & ~16'(INSTR_BYTES - 1);
  endfunction

  // Sequential successor of a fetch address; wraps at the top of the space.
  function automatic logic [15:0] next_pc(input logic [15:0] pc);
    return pc + 16'(INSTR_BYTES);
  endfunction

endpackage

// File: rtl/cpu_ifetch_fifo.sv
// Small synchronous FIFO of fetch entries. Flush beats push and pop;
// a push into a full FIFO is accepted only when a pop frees a slot in
// the same cycle.
module cpu_ifetch_fifo
  import cpu_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             push,
  input  fetch_entry_t     push_entry,
  input  logic             pop,
  output logic [CNT_W-1:0] count,
  output fetch_entry_t     head
);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             empty;
  logic             full;
  logic             pop_ok;
  logic             push_ok;

  // Qualify requests against occupancy; a pop on empty is a no-op.
  always_comb begin
    empty   = (count == '0);
    full    = (count == CNT_W'(DEPTH));
    pop_ok  = pop && !empty;
    push_ok = push && (!full || pop_ok);
  end

  // Pointers and occupancy; DEPTH is a power of two so pointers wrap freely.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage; never reset, contents only matter while count covers them.
  always_ff @(posedge clock) begin
    if (push_ok && !flush) mem[wr_ptr] <= push_entry;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/cpu_ifetch.sv
// Instruction-fetch initiator: issues one-cycle fetch requests, collects
// in-order responses into a prefetch FIFO and hands them to decode.
// A redirect flushes the FIFO and drops every response to a request that
// was issued before the redirect cycle.
module cpu_ifetch
  import cpu_pkg::*;
#(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] RESET_PC   = 16'h0000
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic        cpui_request,
  output logic [15:0] cpui_addr,
  input  logic [31:0] cpui_rdata,
  input  logic        cpui_ack,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  output logic        dec_valid,
  output logic [31:0] dec_instr,
  output logic [15:0] dec_pc,
  input  logic        dec_ready
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W:0] CREDIT_LIMIT = (CNT_W + 1)'(FIFO_DEPTH);

  logic [15:0]      fetch_pc;
  logic [15:0]      fetch_pc_nxt;
  logic [15:0]      resp_pc;
  logic [15:0]      resp_pc_nxt;
  logic [15:0]      redirect_base;
  logic [CNT_W-1:0] outstanding;
  logic [CNT_W-1:0] outstanding_nxt;
  logic [CNT_W-1:0] discard;
  logic [CNT_W-1:0] discard_nxt;
  logic [CNT_W-1:0] fifo_count;
  logic [CNT_W:0]   credit_used;
  logic             ack_ok;
  logic             issue;
  logic             push;
  logic             pop;
  fetch_entry_t     push_entry;
  fetch_entry_t     head_entry;

  // Issue/accept decisions and next-state values for the fetch bookkeeping.
  always_comb begin
    redirect_base = align_pc(redirect_pc);

    // A spurious ack (nothing outstanding) is ignored so counters never underflow.
    ack_ok = cpui_ack && (outstanding != '0);

    // Conservative credit: pre-pop occupancy plus everything still in flight,
    // including stale requests that will be discarded on return.
    credit_used = {1'b0, outstanding} + {1'b0, fifo_count};
    issue       = !redirect_valid && (credit_used < CREDIT_LIMIT);

    // Only current-stream responses land in the FIFO.
    push             = ack_ok && !redirect_valid && (discard == '0);
    push_entry.pc    = resp_pc;
    push_entry.instr = cpui_rdata;

    // Flush has priority inside the FIFO, so a pop in a redirect cycle is void.
    pop = dec_valid && dec_ready && !redirect_valid;

    outstanding_nxt = outstanding;
    if (issue)  outstanding_nxt = outstanding_nxt + CNT_W'(1);
    if (ack_ok) outstanding_nxt = outstanding_nxt - CNT_W'(1);

    // On redirect everything still outstanding belongs to the old stream;
    // outstanding already counts last cycle's request, and no issue can
    // happen in the redirect cycle, so the post-ack outstanding is exact.
    discard_nxt = discard;
    if (redirect_valid) begin
      discard_nxt = ack_ok ? (outstanding - CNT_W'(1)) : outstanding;
    end else if (ack_ok && (discard != '0)) begin
      discard_nxt = discard - CNT_W'(1);
    end

    fetch_pc_nxt = fetch_pc;
    if (redirect_valid)  fetch_pc_nxt = redirect_base;
    else if (issue)      fetch_pc_nxt = next_pc(fetch_pc);

    resp_pc_nxt = resp_pc;
    if (redirect_valid)  resp_pc_nxt = redirect_base;
    else if (push)       resp_pc_nxt = next_pc(resp_pc);
  end

  // Fetch state and the registered request toward instruction RAM.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc     <= RESET_PC;
      resp_pc      <= RESET_PC;
      outstanding  <= '0;
      discard      <= '0;
      cpui_request <= 1'b0;
      cpui_addr    <= RESET_PC;
    end else begin
      fetch_pc     <= fetch_pc_nxt;
      resp_pc      <= resp_pc_nxt;
      outstanding  <= outstanding_nxt;
      discard      <= discard_nxt;
      cpui_request <= issue;
      if (issue) cpui_addr <= fetch_pc;
    end
  end

  cpu_ifetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock      (clock),
    .reset_n    (reset_n),
    .flush      (redirect_valid),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .count      (fifo_count),
    .head       (head_entry)
  );

  // Decode side is driven directly from the registered FIFO head.
  always_comb begin
    dec_valid = (fifo_count != '0);
    dec_instr = head_entry.instr;
    dec_pc    = head_entry.pc;
  end

  // Responder must never ack without a pending request.
  ack_has_request: assert property (@(posedge clock) disable iff (!reset_n)
    cpui_ack |-> (outstanding != '0));

  // Stale responses are always a subset of those still in flight.
  discard_bounded: assert property (@(posedge clock) disable iff (!reset_n)
    discard <= outstanding);

  // In-flight plus buffered work never exceeds the FIFO capacity.
  credit_bounded: assert property (@(posedge clock) disable iff (!reset_n)
    credit_used <= CREDIT_LIMIT);

endmodule

// File: tb/tb_cpu_ifetch.sv
// Bench for cpu_ifetch: an instruction-RAM responder with programmable
// latency, a request-address model and a scoreboard of expected decode
// entries, plus directed timing steps.
module tb_cpu_ifetch;
  import cpu_pkg::*;

  localparam logic [15:0] RST_PC = 16'h0000;

  typedef struct {
    int          due;
    logic [15:0] addr;
    logic [15:0] eaddr;
    int          ep;
  } rsp_t;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        cpui_request;
  logic [15:0] cpui_addr;
  logic [31:0] cpui_rdata = '0;
  logic        cpui_ack = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic        dec_valid;
  logic [31:0] dec_instr;
  logic [15:0] dec_pc;
  logic        dec_ready = 1'b1;

  int           vectors = 0;
  int           miscompares = 0;
  int           lat = 1;
  int           cyc = 0;
  int           epoch = 0;
  int           ack_ep = 0;
  int           req_count = 0;
  logic         redirect_prev = 1'b0;
  logic [15:0]  exp_req_addr = RST_PC;
  rsp_t         rsp_q[$];
  rsp_t         r;
  fetch_entry_t sb_q[$];
  fetch_entry_t exp_e;
  fetch_entry_t new_e;

  cpu_ifetch #(
    .FIFO_DEPTH (4),
    .RESET_PC   (RST_PC)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .cpui_request   (cpui_request),
    .cpui_addr      (cpui_addr),
    .cpui_rdata     (cpui_rdata),
    .cpui_ack       (cpui_ack),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .dec_valid      (dec_valid),
    .dec_instr      (dec_instr),
    .dec_pc         (dec_pc),
    .dec_ready      (dec_ready)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] instr_of(input logic [15:0] a);
    return {a ^ 16'hC35A, a};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic mid();
    @(negedge clock);
  endtask

  task automatic wait_valid(input string tag, input logic [15:0] pc);
    for (int i = 0; i < 20; i++) begin
      if (dec_valid) break;
      next_cyc();
      mid();
    end
    chk({tag, "_valid"}, 32'(dec_valid), 32'd1);
    chk({tag, "_pc"}, 32'(dec_pc), 32'(pc));
    chk({tag, "_instr"}, dec_instr, instr_of(pc));
  endtask

  // Mid-cycle: drive the responder and predict what the next edge does.
  always @(negedge clock) begin
    if (!reset_n) begin
      rsp_q.delete();
      sb_q.delete();
      cpui_ack      = 1'b0;
      cpui_rdata    = '0;
      exp_req_addr  = RST_PC;
      req_count     = 0;
      redirect_prev = 1'b0;
    end else begin
      cpui_ack = 1'b0;
      if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
        r = rsp_q.pop_front();
        cpui_ack   = 1'b1;
        cpui_rdata = instr_of(r.addr);
        ack_ep     = r.ep;
        new_e.pc    = r.eaddr;
        new_e.instr = instr_of(r.eaddr);
      end
      if (dec_valid && dec_ready && !redirect_valid) begin
        if (sb_q.size() == 0) begin
          chk("dec_unexpected_valid", 32'(dec_valid), 32'd0);
        end else begin
          exp_e = sb_q.pop_front();
          chk("sb_dec_pc", 32'(dec_pc), 32'(exp_e.pc));
          chk("sb_dec_instr", dec_instr, exp_e.instr);
        end
      end
      if (cpui_ack && ack_ep == epoch && !redirect_valid) sb_q.push_back(new_e);
      if (redirect_valid) sb_q.delete();
      if (redirect_prev) chk("no_req_after_redirect", 32'(cpui_request), 32'd0);
      if (cpui_request) begin
        chk("req_addr", 32'(cpui_addr), 32'(exp_req_addr));
        r.due   = cyc + lat;
        r.addr  = cpui_addr;
        r.eaddr = exp_req_addr;
        r.ep    = epoch;
        rsp_q.push_back(r);
        exp_req_addr = exp_req_addr + 16'd4;
        req_count++;
      end
      if (redirect_valid) begin
        epoch++;
        exp_req_addr = redirect_pc & 16'hFFFC;
      end
      redirect_prev = redirect_valid;
    end
    cyc++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values and first fetches with a 1-cycle RAM
    reset_n = 1'b0;
    dec_ready = 1'b1;
    lat = 1;
    repeat (3) next_cyc();
    mid();
    chk("rst_request", 32'(cpui_request), 32'd0);
    chk("rst_addr", 32'(cpui_addr), 32'(RST_PC));
    chk("rst_dec_valid", 32'(dec_valid), 32'd0);
    next_cyc();
    reset_n = 1'b1;
    mid();
    chk("idle_after_release", 32'(cpui_request), 32'd0);
    next_cyc(); mid();
    chk("req0", 32'(cpui_request), 32'd1);
    chk("req0_addr", 32'(cpui_addr), 32'h0000);
    chk("req0_dec_valid", 32'(dec_valid), 32'd0);
    next_cyc(); mid();
    chk("req1_addr", 32'(cpui_addr), 32'h0004);
    chk("req1_dec_valid", 32'(dec_valid), 32'd0);
    next_cyc(); mid();
    chk("req2_addr", 32'(cpui_addr), 32'h0008);
    chk("first_dec_valid", 32'(dec_valid), 32'd1);
    chk("first_dec_pc", 32'(dec_pc), 32'h0000);
    for (int i = 1; i <= 8; i++) begin
      next_cyc(); mid();
      chk("stream_valid", 32'(dec_valid), 32'd1);
      chk("stream_pc", 32'(dec_pc), 32'(i * 4));
    end

    // Back-pressure: fill the FIFO, then drain in order
    reset_n = 1'b0;
    next_cyc(); next_cyc();
    dec_ready = 1'b0;
    reset_n = 1'b1;
    repeat (10) next_cyc();
    mid();
    chk("fill_req_count", 32'(req_count), 32'd4);
    chk("fill_request_low", 32'(cpui_request), 32'd0);
    chk("fill_dec_valid", 32'(dec_valid), 32'd1);
    chk("fill_head_pc", 32'(dec_pc), 32'h0000);
    next_cyc();
    dec_ready = 1'b1;
    mid();
    chk("drain_pc0", 32'(dec_pc), 32'h0000);
    chk("drain_no_req", 32'(cpui_request), 32'd0);
    for (int i = 1; i <= 4; i++) begin
      next_cyc(); mid();
      chk("drain_valid", 32'(dec_valid), 32'd1);
      chk("drain_pc", 32'(dec_pc), 32'(i * 4));
      if (i == 1) chk("drain_full_credit", 32'(cpui_request), 32'd0);
      if (i == 2) chk("resume_addr", 32'({cpui_request, cpui_addr}), 32'h1_0010);
    end

    // Slow RAM: redirect with two requests in flight
    reset_n = 1'b0;
    lat = 3;
    next_cyc(); next_cyc();
    reset_n = 1'b1;
    next_cyc();
    next_cyc();
    redirect_valid = 1'b1;
    redirect_pc = 16'h0102;
    mid();
    chk("p3_second_req", 32'({cpui_request, cpui_addr}), 32'h1_0004);
    next_cyc();
    redirect_valid = 1'b0;
    mid();
    chk("p3_no_req_redirect", 32'(cpui_request), 32'd0);
    next_cyc(); mid();
    chk("p3_new_req", 32'({cpui_request, cpui_addr}), 32'h1_0100);
    chk("p3_no_stale", 32'(dec_valid), 32'd0);
    wait_valid("p3_first", 16'h0100);

    // Redirect coinciding with an ack and a pop
    lat = 1;
    repeat (12) next_cyc();
    redirect_valid = 1'b1;
    redirect_pc = 16'h0200;
    mid();
    chk("p4_pre_valid", 32'(dec_valid), 32'd1);
    chk("p4_pre_req", 32'(cpui_request), 32'd1);
    next_cyc();
    redirect_valid = 1'b0;
    mid();
    chk("p4_flushed", 32'(dec_valid), 32'd0);
    chk("p4_no_req", 32'(cpui_request), 32'd0);
    next_cyc(); mid();
    chk("p4_new_req", 32'({cpui_request, cpui_addr}), 32'h1_0200);
    chk("p4_stale_dropped", 32'(dec_valid), 32'd0);
    wait_valid("p4_first", 16'h0200);

    // Back-to-back redirects: the last one wins
    next_cyc();
    redirect_valid = 1'b1;
    redirect_pc = 16'h0300;
    next_cyc();
    redirect_pc = 16'h0401;
    mid();
    chk("b2b_no_req1", 32'(cpui_request), 32'd0);
    next_cyc();
    redirect_valid = 1'b0;
    mid();
    chk("b2b_no_req2", 32'(cpui_request), 32'd0);
    next_cyc(); mid();
    chk("b2b_new_req", 32'({cpui_request, cpui_addr}), 32'h1_0400);
    wait_valid("b2b_first", 16'h0400);

    // Address wrap at the top of the space
    next_cyc();
    redirect_valid = 1'b1;
    redirect_pc = 16'hFFF8;
    next_cyc();
    redirect_valid = 1'b0;
    next_cyc(); mid();
    chk("wrap_req0", 32'({cpui_request, cpui_addr}), 32'h1_FFF8);
    next_cyc(); mid();
    chk("wrap_req1", 32'({cpui_request, cpui_addr}), 32'h1_FFFC);
    next_cyc(); mid();
    chk("wrap_req2", 32'({cpui_request, cpui_addr}), 32'h1_0000);
    chk("wrap_dec0", 32'({dec_valid, dec_pc}), 32'h1_FFF8);
    next_cyc(); mid();
    chk("wrap_dec1", 32'({dec_valid, dec_pc}), 32'h1_FFFC);
    next_cyc(); mid();
    chk("wrap_dec2", 32'({dec_valid, dec_pc}), 32'h1_0000);

    // Asynchronous reset with a full FIFO
    dec_ready = 1'b0;
    repeat (10) next_cyc();
    mid();
    chk("p6_full_valid", 32'(dec_valid), 32'd1);
    next_cyc();
    reset_n = 1'b0;
    #1;
    chk("p6_async_valid", 32'(dec_valid), 32'd0);
    chk("p6_async_req", 32'(cpui_request), 32'd0);
    chk("p6_async_addr", 32'(cpui_addr), 32'(RST_PC));
    next_cyc();
    dec_ready = 1'b1;
    next_cyc();
    reset_n = 1'b1;
    mid();
    chk("p6_idle", 32'(cpui_request), 32'd0);
    next_cyc(); mid();
    chk("p6_restart", 32'({cpui_request, cpui_addr}), 32'h1_0000);
    next_cyc(); next_cyc(); mid();
    chk("p6_first_dec", 32'({dec_valid, dec_pc}), 32'h1_0000);
    repeat (4) next_cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
